// File: rtl/slicer_pkg.sv
// Shared types and constants for the slicer line-buffer scheduler.
// The FILTER watchdog limit here is only used when SLICER_SCHED_TIMEOUT_EN is defined.
package slicer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_FILTER = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int unsigned DEF_WORDS_PER_LINE = 64;
  localparam int unsigned DEF_OUT_BEATS      = 64;
  localparam int unsigned DEF_ROW_W          = 16;
  localparam int unsigned GAP_CYCLES         = 2;
  localparam int unsigned WDOG_LIMIT         = 4096;

endpackage

// File: rtl/slicer_sched_cnt.sv
// Clear/enable counter that flags the enabled cycle carrying the TERMINAL-th event.
module slicer_sched_cnt
  import slicer_pkg::*;
#(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned TERMINAL = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc = i_en && (r_count == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/slicer_sched.sv
// Frame scheduler: fetches rows r-1, r, r+1 into three slicer line buffers, then runs one filter pass per row.
// Optional FILTER watchdog enabled by defining SLICER_SCHED_TIMEOUT_EN.
module slicer_sched
  import slicer_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned OUT_BEATS      = DEF_OUT_BEATS,
  parameter int unsigned ROW_W          = DEF_ROW_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [ROW_W-1:0] i_num_rows,
  output logic             o_rd_req,
  output logic [ROW_W-1:0] o_rd_row,
  input  logic             i_data_valid,
  input  logic [63:0]      i_data,
  output logic             o_data_ack,
  output logic             o_line1_data_valid,
  output logic             o_line2_data_valid,
  output logic             o_line3_data_valid,
  output logic [63:0]      o_line_data,
  output logic             o_filter,
  input  logic             i_out_beat,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE + 1);
  localparam int unsigned BEAT_W = $clog2(OUT_BEATS + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  state_t           r_state;
  state_t           w_next;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] r_num_rows;
  logic [ROW_W-1:0] r_rd_row;
  logic [1:0]       r_k;
  logic [GAP_W-1:0] r_gap;
  logic             r_err;

  logic [ROW_W-1:0] w_req_row;
  logic             w_word_tc;
  logic             w_beat_tc;
  logic             w_gap_end;
  logic             w_more_rows;
  logic             w_start_ok;
  logic             w_timeout;

  assign w_req_row   = r_row - ROW_W'(1) + ROW_W'(r_k);
  assign w_gap_end   = (r_state == ST_GAP) && (r_gap == GAP_W'(GAP_CYCLES - 1));
  assign w_more_rows = r_row < (r_num_rows - ROW_W'(2));
  assign w_start_ok  = i_num_rows >= ROW_W'(3);

  slicer_sched_cnt #(.WIDTH(WORD_W), .TERMINAL(WORDS_PER_LINE)) u_word_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (r_state != ST_LOAD),
    .i_en  ((r_state == ST_LOAD) && i_data_valid),
    .o_tc  (w_word_tc)
  );

  slicer_sched_cnt #(.WIDTH(BEAT_W), .TERMINAL(OUT_BEATS)) u_beat_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (r_state != ST_FILTER),
    .i_en  ((r_state == ST_FILTER) && i_out_beat),
    .o_tc  (w_beat_tc)
  );

`ifdef SLICER_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] r_wdog;

  // Counts consecutive FILTER cycles with no result beat from the slicer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wdog <= '0;
    end else if ((r_state != ST_FILTER) || i_out_beat) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_FILTER) && !i_out_beat && (r_wdog == WD_W'(WDOG_LIMIT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next             = r_state;
    o_rd_req           = 1'b0;
    o_data_ack         = 1'b0;
    o_line1_data_valid = 1'b0;
    o_line2_data_valid = 1'b0;
    o_line3_data_valid = 1'b0;
    o_line_data        = '0;
    o_filter           = 1'b0;
    o_busy             = 1'b0;
    o_done             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = w_start_ok ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        o_rd_req = 1'b1;
        o_busy   = 1'b1;
        w_next   = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy             = 1'b1;
        o_data_ack         = i_data_valid;
        o_line_data        = i_data;
        o_line1_data_valid = i_data_valid && (r_k == 2'd0);
        o_line2_data_valid = i_data_valid && (r_k == 2'd1);
        o_line3_data_valid = i_data_valid && (r_k == 2'd2);
        if (w_word_tc) w_next = (r_k == 2'd2) ? ST_FILTER : ST_REQ;
      end
      ST_FILTER: begin
        o_busy   = 1'b1;
        o_filter = 1'b1;
        if (w_beat_tc) begin
          w_next = ST_GAP;
        end else if (w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_GAP: begin
        o_busy = 1'b1;
        if (w_gap_end) w_next = w_more_rows ? ST_REQ : ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Row/slot bookkeeping; the error flag is re-evaluated on every accepted start.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_row      <= '0;
      r_num_rows <= '0;
      r_rd_row   <= '0;
      r_k        <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_err      <= !w_start_ok;
            r_num_rows <= i_num_rows;
            r_row      <= ROW_W'(1);
            r_k        <= 2'd0;
          end
        end
        ST_REQ: r_rd_row <= w_req_row;
        ST_LOAD: begin
          if (w_word_tc && (r_k != 2'd2)) r_k <= r_k + 2'd1;
        end
        ST_FILTER: begin
          if (w_timeout) r_err <= 1'b1;
        end
        ST_GAP: begin
          if (w_gap_end && w_more_rows) begin
            r_row <= r_row + ROW_W'(1);
            r_k   <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_gap <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap <= r_gap + GAP_W'(1);
    end else begin
      r_gap <= '0;
    end
  end

  assign o_rd_row = (r_state == ST_REQ) ? w_req_row : r_rd_row;
  assign o_err    = r_err;

endmodule

// File: doc/slicer_sched.md
SLICER_SCHED -- requirements
Module: slicer_sched

Interface
REQ-001 Parameter WORDS_PER_LINE, default 64: 64-bit words per image row loaded into one line buffer.
REQ-002 Parameter OUT_BEATS, default 64: 64-bit result words expected from the slicer per filtered row.
REQ-003 Parameter ROW_W, default 16: width of row count and row index.
REQ-004 i_clk  in  1  sole clock; all logic rising-edge.
REQ-005 i_rst  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle pulse; begins a frame when idle.
REQ-007 i_num_rows  in  ROW_W  frame height; sampled on accepted i_start.
REQ-008 o_rd_req  out  1  one-cycle pulse requesting one row from the host.
REQ-009 o_rd_row  out  ROW_W  row index for o_rd_req; held until the next request.
REQ-010 i_data_valid / i_data  in  1 / 64  host row stream.
REQ-011 o_data_ack  out  1  host word accepted.
REQ-012 o_line1_data_valid, o_line2_data_valid, o_line3_data_valid  out  1 each  one-hot write strobe to slicer line buffer 1/2/3.
REQ-013 o_line_data  out  64  shared write data to all three line buffers.
REQ-014 o_filter  out  1  slicer filter enable.
REQ-015 i_out_beat  in  1  one slicer result word consumed (sobel valid AND ack).
REQ-016 o_busy / o_done / o_err  out  1 each  frame active / one-cycle frame-complete pulse / sticky error.

Function
REQ-017 States IDLE, REQ, LOAD, FILTER, GAP, DONE; encoding fixed in shared package.
REQ-018 IDLE: i_start with i_num_rows>=3 -> REQ, r=1 (current output row), k=0 (line slot), o_busy=1; o_err cleared on accepted i_start.
REQ-019 i_start with i_num_rows<3 -> DONE directly, o_err=1, no rows requested.
REQ-020 REQ: one-cycle o_rd_req, o_rd_row=r-1+k -> LOAD.
REQ-021 LOAD: o_data_ack=i_data_valid; per accepted word, line strobe k+1 asserted same cycle, o_line_data=i_data combinationally, word counter increments.
REQ-022 After WORDS_PER_LINE accepted words: k<2 -> k+1, REQ; k==2 -> FILTER.
REQ-023 FILTER: o_filter=1; count i_out_beat; on OUT_BEATS-th beat -> GAP, o_filter=0 next cycle.
REQ-024 GAP: o_filter=0 for exactly 2 cycles (lets slicer return to its idle state); then r<i_num_rows-2 -> r+1, k=0, REQ; else DONE.
REQ-025 DONE: o_done=1 one cycle, o_busy=0 -> IDLE.
REQ-026 i_start outside IDLE ignored; i_out_beat outside FILTER ignored, counted by no counter.
REQ-027 o_data_ack=0 and all line strobes 0 outside LOAD; never two strobes in one cycle.
REQ-028 Counters wrap-free: word counter ceil(log2(WORDS_PER_LINE+1)) bits, beat counter sized for OUT_BEATS, both cleared on state entry.
REQ-029 Row-request order per output row: r-1, r, r+1 into lines 1, 2, 3 respectively.

Reset
REQ-030 On i_rst low, immediately: state IDLE, all counters 0, o_rd_req, o_data_ack, line strobes, o_filter, o_busy, o_done, o_err = 0, o_rd_row=0, o_line_data=0.
REQ-031 Reset mid-frame abandons the frame without o_done; first post-reset action requires a new i_start.

Configuration
REQ-032 Macro SLICER_SCHED_TIMEOUT_EN defined: FILTER watchdog of 4096 cycles without i_out_beat -> o_err=1, o_filter=0, DONE.
REQ-033 Macro absent: no watchdog logic; FILTER waits indefinitely.

Structure
REQ-034 Package slicer_pkg holds state enum, default WORDS_PER_LINE/OUT_BEATS/ROW_W, GAP length 2, watchdog limit 4096.
REQ-035 One sub-module slicer_sched_cnt: parameterized clear/enable/terminal-count counter, instantiated for words and beats.

Verification
REQ-036 i_num_rows=3, host always valid -> exactly 3 o_rd_req (rows 0,1,2), 64 strobes each on lines 1,2,3, one FILTER, o_done after 64 beats.
REQ-037 i_num_rows=5 -> 9 requests, rows 0,1,2,1,2,3,2,3,4; 3 FILTER phases, 2-cycle o_filter low between.
REQ-038 i_num_rows=2 -> o_done and o_err next cycles, zero o_rd_req.
REQ-039 i_data_valid toggling every cycle in LOAD -> ack only when valid, exactly 64 strobes per line, no early FILTER.
REQ-040 i_rst low during LOAD of line 2 -> all outputs 0 same cycle; new i_start restarts at row 0.
REQ-041 With SLICER_SCHED_TIMEOUT_EN, no i_out_beat for 4096 FILTER cycles -> o_err=1, o_done pulse, IDLE.
